tt_mux_slot_ctrl: RTL and testbench

TT_MUX_SLOT_CTRL -- requirements
Module: tt_mux_slot_ctrl

---
 rtl/tt_mux_pkg.sv | 5 +
 rtl/tt_mux_ow_select.sv | 12 +
 rtl/tt_mux_slot_ctrl.sv | 84 ++++++++
 tb/tb_tt_mux_slot_ctrl.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/tt_mux_pkg.sv
// tt_mux_pkg: shared FSM state encoding and counter width for the slot mux controller.
package tt_mux_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_DRAIN, ST_GUARD} state_t;
  localparam int CNT_W = 8;
endpackage

// File: rtl/tt_mux_ow_select.sv
// tt_mux_ow_select: picks one OW_W-wide slot output word out of the packed slot bus.
module tt_mux_ow_select #(
  parameter int NUM_SLOTS = 16,
  parameter int OW_W = 24,
  localparam int SW = $clog2(NUM_SLOTS)
) (
  input  logic [NUM_SLOTS*OW_W-1:0] ow_in,
  input  logic [SW-1:0]             idx,
  output logic [OW_W-1:0]           ow
);
  assign ow = ow_in[idx*OW_W +: OW_W];
endmodule

// File: rtl/tt_mux_slot_ctrl.sv
// tt_mux_slot_ctrl: slot enable sequencer with drain/guard gaps between slot switches.
// Define TT_MUX_OW_REG_EN to register ow_out (one extra cycle of latency).
module tt_mux_slot_ctrl
  import tt_mux_pkg::*;
#(
  parameter int NUM_SLOTS = 16,
  parameter int IW_W = 18,
  parameter int OW_W = 24,
  parameter int DRAIN_CYCLES = 4,
  parameter int GUARD_CYCLES = 2,
  parameter logic [IW_W-1:0] IW_SAFE = '0,
  localparam int SW = $clog2(NUM_SLOTS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sel_valid,
  output logic                      sel_ready,
  input  logic                      sel_off,
  input  logic [SW-1:0]             sel_addr,
  input  logic [IW_W-1:0]           iw_in,
  output logic [IW_W-1:0]           iw_out,
  output logic [NUM_SLOTS-1:0]      ena_out,
  input  logic [NUM_SLOTS*OW_W-1:0] ow_in,
  output logic [OW_W-1:0]           ow_out,
  output logic [SW-1:0]             active_slot,
  output logic                      busy
);
  state_t state, nxt;
  logic [CNT_W-1:0] cnt;
  logic [SW-1:0] pend;
  logic pend_vld, accept, req_en, done;
  logic [OW_W-1:0] ow_sel;
  assign sel_ready = !rst && (state == ST_IDLE || state == ST_ACTIVE);
  assign accept = sel_valid && sel_ready;
  assign req_en = !sel_off && int'(sel_addr) < NUM_SLOTS;
  assign done = cnt <= CNT_W'(1);
  assign busy = state == ST_DRAIN || state == ST_GUARD;
  assign ena_out = state == ST_ACTIVE ? NUM_SLOTS'(1) << active_slot : '0;
  always_comb begin
    nxt = state;
    if (state == ST_IDLE && accept && req_en) nxt = ST_GUARD;
    else if (state == ST_ACTIVE && accept) nxt = ST_DRAIN;
    else if (state == ST_DRAIN && done) nxt = pend_vld ? ST_GUARD : ST_IDLE;
    else if (state == ST_GUARD && done) nxt = ST_ACTIVE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt <= '0;
      pend <= '0;
      pend_vld <= 1'b0;
      active_slot <= '0;
      iw_out <= IW_SAFE;
    end else begin
      state <= nxt;
      iw_out <= nxt == ST_ACTIVE ? iw_in : IW_SAFE;
      cnt <= (nxt == ST_DRAIN && state != ST_DRAIN) ? CNT_W'(DRAIN_CYCLES) :
             (nxt == ST_GUARD && state != ST_GUARD) ? CNT_W'(GUARD_CYCLES) :
             cnt != '0 ? cnt - 1'b1 : cnt;
      if (accept) begin
        pend <= sel_addr;
        pend_vld <= req_en;
      end
      if (state == ST_GUARD && nxt == ST_ACTIVE) begin
        active_slot <= pend;
        pend_vld <= 1'b0;
      end
    end
  end
  tt_mux_ow_select #(.NUM_SLOTS(NUM_SLOTS), .OW_W(OW_W)) u_ow_select (
    .ow_in(ow_in),
    .idx(active_slot),
    .ow(ow_sel)
  );
`ifdef TT_MUX_OW_REG_EN
  // Only words sampled while the slot stays enabled pass, so a switch never leaks a stale word.
  always_ff @(posedge clk) begin
    if (rst) ow_out <= '0;
    else ow_out <= (state == ST_ACTIVE && nxt == ST_ACTIVE) ? ow_sel : '0;
  end
`else
  assign ow_out = state == ST_ACTIVE ? ow_sel : '0;
`endif
endmodule

// File: tb/tb_tt_mux_slot_ctrl.sv
// tb_tt_mux_slot_ctrl: scoreboard bench; a cycle model queues expected outputs per edge.
// Uses NUM_SLOTS=12 so that out-of-range slot addresses are representable.
module tb_tt_mux_slot_ctrl;
  localparam int NS = 12;
  localparam int IWW = 18;
  localparam int OWW = 24;
  localparam int S_IDLE = 0, S_ACT = 1, S_DRN = 2, S_GRD = 3;
  typedef struct {
    logic [NS-1:0]  ena;
    logic [IWW-1:0] iw;
    logic [OWW-1:0] ow;
    logic [3:0]     slot;
    logic           busy;
  } exp_t;
  logic clk = 1'b0;
  logic rst, sel_valid, sel_ready, sel_off, busy;
  logic [3:0] sel_addr, active_slot;
  logic [IWW-1:0] iw_in, iw_out;
  logic [NS-1:0] ena_out;
  logic [NS*OWW-1:0] ow_in;
  logic [OWW-1:0] ow_out;
  exp_t q[$];
  int n_chk = 0, n_pass = 0;
  int m_st = S_IDLE, m_left = 0;
  logic [3:0] m_pend = '0, m_slot = '0;
  logic m_pv = 1'b0;
  always #5 clk = ~clk;
  tt_mux_slot_ctrl #(.NUM_SLOTS(NS)) dut (
    .clk(clk), .rst(rst), .sel_valid(sel_valid), .sel_ready(sel_ready),
    .sel_off(sel_off), .sel_addr(sel_addr), .iw_in(iw_in), .iw_out(iw_out),
    .ena_out(ena_out), .ow_in(ow_in), .ow_out(ow_out),
    .active_slot(active_slot), .busy(busy)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
  endtask
  function automatic logic [OWW-1:0] slice(input logic [3:0] k);
    return ow_in[int'(k)*OWW +: OWW];
  endfunction
  task automatic cyc(input logic r, input logic v, input logic o, input logic [3:0] a);
    exp_t e;
    logic acc, en, prev_act;
    @(negedge clk);
    rst = r; sel_valid = v; sel_off = o; sel_addr = a;
    iw_in = IWW'($urandom);
    #1;
    chk("sel_ready", sel_ready, !r && (m_st == S_IDLE || m_st == S_ACT));
    acc = v && !r && (m_st == S_IDLE || m_st == S_ACT);
    en = !o && int'(a) < NS;
    prev_act = m_st == S_ACT;
    if (r) begin
      m_st = S_IDLE; m_left = 0; m_pv = 1'b0; m_slot = '0;
    end else if (m_st == S_IDLE) begin
      if (acc && en) begin m_pend = a; m_st = S_GRD; m_left = 2; end
    end else if (m_st == S_ACT) begin
      if (acc) begin m_pend = a; m_pv = en; m_st = S_DRN; m_left = 4; end
    end else begin
      m_left--;
      if (m_left == 0) begin
        if (m_st == S_GRD) begin
          m_st = S_ACT; m_slot = m_pend; m_pv = 1'b0;
        end else if (m_pv) begin
          m_st = S_GRD; m_left = 2;
        end else m_st = S_IDLE;
      end
    end
    e.ena = m_st == S_ACT ? NS'(1) << m_slot : '0;
    e.iw = m_st == S_ACT ? iw_in : '0;
    e.slot = m_slot;
    e.busy = m_st == S_DRN || m_st == S_GRD;
`ifdef TT_MUX_OW_REG_EN
    e.ow = (prev_act && m_st == S_ACT) ? slice(m_slot) : '0;
`else
    e.ow = m_st == S_ACT ? slice(m_slot) : '0;
    if (prev_act) e.ow = e.ow;
`endif
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("ena_out", ena_out, e.ena);
    chk("iw_out", iw_out, e.iw);
    chk("ow_out", ow_out, e.ow);
    chk("active_slot", active_slot, e.slot);
    chk("busy", busy, e.busy);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 4'd0);
  endtask
  initial begin
    rst = 1'b1; sel_valid = 1'b0; sel_off = 1'b0; sel_addr = '0; iw_in = '0;
    for (int k = 0; k < NS; k++) ow_in[k*OWW +: OWW] = {8'(k), 16'hC3C3 ^ 16'(k)};
    ow_in[7*OWW +: OWW] = 24'hA5A5A5;
    cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
    chk("reset_ena", ena_out, '0);
    chk("reset_iw", iw_out, '0);
    cyc(0, 1, 1, 4);
    chk("off_in_idle_busy", busy, 1'b0);
    cyc(0, 1, 0, 5);
    cyc(0, 0, 0, 0);
    chk("guard_ena_zero", ena_out, '0);
    cyc(0, 0, 0, 0);
    chk("slot5_ena", ena_out, 12'h020);
    idle(3);
    cyc(0, 1, 0, 9);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 0);
      chk("switch_ena_gap", ena_out, '0);
      chk("switch_iw_safe", iw_out, '0);
    end
    cyc(0, 0, 0, 0);
    chk("slot9_ena", ena_out, 12'h200);
    chk("slot9_idx", active_slot, 4'd9);
    cyc(0, 1, 0, 9);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 0);
      chk("reselect_low", ena_out[9], 1'b0);
    end
    cyc(0, 0, 0, 0);
    chk("reselect_high", ena_out[9], 1'b1);
    cyc(0, 1, 0, 7);
    cyc(0, 1, 0, 2); cyc(0, 1, 1, 0);
    idle(6);
    chk("slot7_ow", ow_out, 24'hA5A5A5);
    chk("slot7_ena", ena_out, 12'h080);
    for (int k = 0; k < NS; k++) ow_in[k*OWW +: OWW] = OWW'($urandom);
    idle(2);
    cyc(0, 1, 0, 14);
    idle(8);
    chk("oob_ena", ena_out, '0);
    chk("oob_busy", busy, 1'b0);
    cyc(0, 1, 0, 3);
    idle(4);
    chk("slot3_ena", ena_out, 12'h008);
    cyc(0, 1, 0, 5);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("rst_drain_busy", busy, 1'b0);
    chk("rst_drain_slot", active_slot, 4'd0);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 0, 0);
      chk("no_pending_ena", ena_out, '0);
    end
    for (int i = 0; i < 60; i++)
      cyc(($urandom_range(0, 29) == 0), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 5) == 0), 4'($urandom_range(0, 15)));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
